// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared state encoding, data-format constants and width helpers for the stream feeder
package sa_pkg;

    typedef enum logic [5:0] {
        ST_IDLE  = 6'b000001,
        ST_CLR   = 6'b000010,
        ST_LOAD  = 6'b000100,
        ST_FLUSH = 6'b001000,
        ST_WAIT  = 6'b010000,
        ST_DONE  = 6'b100000
    } sa_state_e;

    // Q2.13 operands
    localparam int SA_D_W       = 16;
    localparam int SA_FRAC_BITS = 13;

    function automatic int sa_cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int sa_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sa_stream_feeder_if.sv
// rtl/sa_stream_feeder_if.sv - operand-pair handshake between the matrix buffers and the feeder
interface sa_stream_feeder_if #(
    parameter int D_W  = 16,
    parameter int SA_R = 16,
    parameter int SA_C = 16
);
    logic                I_VEC_VLD;
    logic                O_VEC_RDY;
    logic [SA_R*D_W-1:0] I_X_VEC;
    logic [SA_C*D_W-1:0] I_W_VEC;

    modport master (output I_VEC_VLD, output I_X_VEC, output I_W_VEC, input O_VEC_RDY);
    modport slave  (input I_VEC_VLD, input I_X_VEC, input I_W_VEC, output O_VEC_RDY);
endinterface

// File: rtl/sa_skew_line.sv
// rtl/sa_skew_line.sv - per-lane step-enabled delay line followed by the lane output register
module sa_skew_line #(
    parameter int D_W   = 16,
    parameter int DEPTH = 0
) (
    input  logic           I_CLK,
    input  logic           I_ASYN_RSTN,
    input  logic           I_SYNC_RSTN,
    input  logic           i_step,
    input  logic [D_W-1:0] i_din,
    output logic [D_W-1:0] o_dout
);

    logic [D_W-1:0] tap;
    logic [D_W-1:0] out_q, out_d;

    generate
        if (DEPTH == 0) begin : g_direct
            assign tap = i_din;
        end else begin : g_line
            logic [D_W-1:0] line_q [DEPTH];
            logic [D_W-1:0] line_d [DEPTH];

            always_comb begin
                line_d = line_q;
                if (i_step) begin
                    line_d[0] = i_din;
                    for (int k = 1; k < DEPTH; k++) begin
                        line_d[k] = line_q[k-1];
                    end
                end
            end

            always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
                if (!I_ASYN_RSTN) begin
                    for (int k = 0; k < DEPTH; k++) line_q[k] <= '0;
                end else if (!I_SYNC_RSTN) begin
                    for (int k = 0; k < DEPTH; k++) line_q[k] <= '0;
                end else begin
                    line_q <= line_d;
                end
            end

            assign tap = line_q[DEPTH-1];
        end
    endgenerate

    always_comb begin
        out_d = out_q;
        if (i_step) out_d = tap;
    end

    always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
        if (!I_ASYN_RSTN) begin
            out_q <= '0;
        end else if (!I_SYNC_RSTN) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign o_dout = out_q;

endmodule

// File: rtl/sa_stream_feeder.sv
// rtl/sa_stream_feeder.sv - skewing, paced operand feeder for the PE array; SA_FEED_STALL_CNT_EN adds O_STALL_CNT
module sa_stream_feeder
    import sa_pkg::*;
#(
    parameter int D_W          = SA_D_W,
    parameter int SA_R         = 16,
    parameter int SA_C         = 16,
    parameter int MAX_K        = 64,
    parameter int SHIFT_PERIOD = 5,
    parameter int PE_LAT       = 4
) (
    input  logic                         I_CLK,
    input  logic                         I_ASYN_RSTN,
    input  logic                         I_SYNC_RSTN,
    input  logic                         I_START,
    input  logic [$clog2(MAX_K+1)-1:0]   I_K_LEN,
    input  logic                         I_ACC_MODE,
    sa_stream_feeder_if.slave            vec_if,
    output logic [SA_R*D_W-1:0]          O_X_SKEW,
    output logic [SA_C*D_W-1:0]          O_W_SKEW,
    output logic                         O_PE_SHIFT,
    output logic                         O_PE_CLR,
    output logic                         O_BUSY,
    output logic                         O_DONE
`ifdef SA_FEED_STALL_CNT_EN
    ,
    output logic [15:0]                  O_STALL_CNT
`endif
);

    localparam int KW      = $clog2(MAX_K + 1);
    localparam int FLUSH_N = SA_R + SA_C - 2;
    localparam int CW      = sa_cnt_w(sa_max(sa_max(MAX_K, FLUSH_N), PE_LAT));
    localparam int DIVW    = sa_cnt_w(SHIFT_PERIOD);

    localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(SHIFT_PERIOD - 1);
    localparam logic [CW-1:0]   FLUSH_CNT = CW'(FLUSH_N);
    localparam logic [CW-1:0]   WAIT_LAST = CW'((PE_LAT > 0) ? PE_LAT - 1 : 0);

    sa_state_e         state_q, state_d;
    logic [DIVW-1:0]   div_q, div_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [KW-1:0]     k_len_q, k_len_d;
    logic              acc_q, acc_d;
    logic              shift_q;
    logic              step;
    logic              div_end;
    logic              vec_rdy;
    logic              load_sel;
    logic [CW-1:0]     cnt_inc;
    logic [CW-1:0]     k_cnt;

    assign div_end  = (div_q == DIV_LAST);
    assign vec_rdy  = (state_q == ST_LOAD) && div_end;
    assign load_sel = (state_q == ST_LOAD);
    assign cnt_inc  = cnt_q + CW'(1);
    assign k_cnt    = CW'(k_len_q);

    // cnt_q is shared: K steps in LOAD, flush steps in FLUSH, latency cycles in WAIT
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        k_len_d = k_len_q;
        acc_d   = acc_q;
        step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (I_START) begin
                    k_len_d = I_K_LEN;
                    acc_d   = I_ACC_MODE;
                    cnt_d   = '0;
                    state_d = (I_K_LEN == '0) ? ST_DONE : ST_CLR;
                end
            end
            ST_CLR: begin
                div_d   = '0;
                cnt_d   = '0;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (div_end) begin
                    if (vec_if.I_VEC_VLD) begin
                        step  = 1'b1;
                        div_d = '0;
                        cnt_d = cnt_inc;
                        if (cnt_inc == k_cnt) begin
                            cnt_d   = '0;
                            state_d = (FLUSH_N == 0) ? ST_WAIT : ST_FLUSH;
                        end
                    end
                end else begin
                    div_d = div_q + DIVW'(1);
                end
            end
            ST_FLUSH: begin
                if (div_end) begin
                    step  = 1'b1;
                    div_d = '0;
                    cnt_d = cnt_inc;
                    if (cnt_inc == FLUSH_CNT) begin
                        cnt_d   = '0;
                        state_d = ST_WAIT;
                    end
                end else begin
                    div_d = div_q + DIVW'(1);
                end
            end
            ST_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
        if (!I_ASYN_RSTN) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            k_len_q <= '0;
            acc_q   <= 1'b0;
            shift_q <= 1'b0;
        end else if (!I_SYNC_RSTN) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            k_len_q <= '0;
            acc_q   <= 1'b0;
            shift_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            k_len_q <= k_len_d;
            acc_q   <= acc_d;
            shift_q <= step;
        end
    end

    assign vec_if.O_VEC_RDY = vec_rdy;
    assign O_PE_SHIFT       = shift_q;
    assign O_PE_CLR         = (state_q == ST_CLR) && !acc_q;
    assign O_BUSY           = (state_q != ST_IDLE);
    assign O_DONE           = (state_q == ST_DONE);

    // Lane i is delayed i steps so diagonal wavefronts meet inside the array; FLUSH feeds zeros
    for (genvar i = 0; i < SA_R; i++) begin : g_x
        sa_skew_line #(.D_W(D_W), .DEPTH(i)) u_line (
            .I_CLK       (I_CLK),
            .I_ASYN_RSTN (I_ASYN_RSTN),
            .I_SYNC_RSTN (I_SYNC_RSTN),
            .i_step      (step),
            .i_din       (load_sel ? vec_if.I_X_VEC[i*D_W +: D_W] : {D_W{1'b0}}),
            .o_dout      (O_X_SKEW[i*D_W +: D_W])
        );
    end

    for (genvar j = 0; j < SA_C; j++) begin : g_w
        sa_skew_line #(.D_W(D_W), .DEPTH(j)) u_line (
            .I_CLK       (I_CLK),
            .I_ASYN_RSTN (I_ASYN_RSTN),
            .I_SYNC_RSTN (I_SYNC_RSTN),
            .i_step      (step),
            .i_din       (load_sel ? vec_if.I_W_VEC[j*D_W +: D_W] : {D_W{1'b0}}),
            .o_dout      (O_W_SKEW[j*D_W +: D_W])
        );
    end

`ifdef SA_FEED_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == ST_IDLE) && I_START) begin
            stall_d = '0;
        end else if (vec_rdy && !vec_if.I_VEC_VLD && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
        if (!I_ASYN_RSTN) begin
            stall_q <= '0;
        end else if (!I_SYNC_RSTN) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign O_STALL_CNT = stall_q;
`endif

endmodule

// File: tb/tb_sa_stream_feeder.sv
// tb/tb_sa_stream_feeder.sv - directed bench for a 4x4 period-5 feeder and a 1x1 period-1 feeder
module tb_sa_stream_feeder;

    localparam int DW  = 16;
    localparam int LAT = 4;
    localparam int KW  = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          arstn, srstn4, srstn1;
    logic          start4, acc4, start1, acc1;
    logic [KW-1:0] k4, k1;
    logic [63:0]   x4, w4;
    logic [15:0]   x1, w1;
    logic          shift4, clr4, busy4, done4;
    logic          shift1, clr1, busy1, done1;
`ifdef SA_FEED_STALL_CNT_EN
    logic [15:0]   stall4, stall1;
`endif

    sa_stream_feeder_if #(.D_W(DW), .SA_R(4), .SA_C(4)) vif4();
    sa_stream_feeder_if #(.D_W(DW), .SA_R(1), .SA_C(1)) vif1();

    sa_stream_feeder #(.D_W(DW), .SA_R(4), .SA_C(4), .MAX_K(64), .SHIFT_PERIOD(5), .PE_LAT(LAT)) dut4 (
        .I_CLK(clk), .I_ASYN_RSTN(arstn), .I_SYNC_RSTN(srstn4), .I_START(start4),
        .I_K_LEN(k4), .I_ACC_MODE(acc4), .vec_if(vif4), .O_X_SKEW(x4), .O_W_SKEW(w4),
        .O_PE_SHIFT(shift4), .O_PE_CLR(clr4), .O_BUSY(busy4), .O_DONE(done4)
`ifdef SA_FEED_STALL_CNT_EN
        , .O_STALL_CNT(stall4)
`endif
    );

    sa_stream_feeder #(.D_W(DW), .SA_R(1), .SA_C(1), .MAX_K(64), .SHIFT_PERIOD(1), .PE_LAT(LAT)) dut1 (
        .I_CLK(clk), .I_ASYN_RSTN(arstn), .I_SYNC_RSTN(srstn1), .I_START(start1),
        .I_K_LEN(k1), .I_ACC_MODE(acc1), .vec_if(vif1), .O_X_SKEW(x1), .O_W_SKEW(w1),
        .O_PE_SHIFT(shift1), .O_PE_CLR(clr1), .O_BUSY(busy1), .O_DONE(done1)
`ifdef SA_FEED_STALL_CNT_EN
        , .O_STALL_CNT(stall1)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    int          n_sh4 = 0, n_clr4 = 0, n_dn4 = 0, dn_cyc4 = 0;
    int          n_sh1 = 0, n_clr1 = 0, n_dn1 = 0, dn_cyc1 = 0;
    int          sh_cyc4 [256];
    logic [15:0] sh_x3 [256];
    logic [15:0] sh_x0 [256];
    logic [15:0] sh_w3 [256];
    int          sh_cyc1 [64];
    logic [15:0] sh_x1 [64];
    logic [15:0] sh_w1 [64];

    always @(negedge clk) begin
        if (shift4 === 1'b1) begin
            if (n_sh4 < 256) begin
                sh_cyc4[n_sh4] = cyc;
                sh_x3[n_sh4]   = x4[63:48];
                sh_x0[n_sh4]   = x4[15:0];
                sh_w3[n_sh4]   = w4[63:48];
            end
            n_sh4++;
        end
        if (clr4 === 1'b1) n_clr4++;
        if (done4 === 1'b1) begin n_dn4++; dn_cyc4 = cyc; end
        if (shift1 === 1'b1) begin
            if (n_sh1 < 64) begin
                sh_cyc1[n_sh1] = cyc;
                sh_x1[n_sh1]   = x1;
                sh_w1[n_sh1]   = w1;
            end
            n_sh1++;
        end
        if (clr1 === 1'b1) n_clr1++;
        if (done1 === 1'b1) begin n_dn1++; dn_cyc1 = cyc; end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job4(input int k, input logic acc);
        k4 = KW'(k); acc4 = acc; start4 = 1'b1;
        tick();
        start4 = 1'b0;
    endtask

    task automatic feed4(input int nvec, input int stall_idx, input int stall_len,
                         output int timeouts, output int rdy_drops);
        logic [63:0] xv, wv;
        int g;
        timeouts = 0; rdy_drops = 0;
        for (int k = 0; k < nvec; k++) begin
            for (int i = 0; i < 4; i++) begin
                xv[i*16 +: 16] = 16'(16*k + i);
                wv[i*16 +: 16] = 16'(100 + 16*k + i);
            end
            vif4.I_X_VEC = xv; vif4.I_W_VEC = wv;
            if (k == stall_idx) begin
                vif4.I_VEC_VLD = 1'b0;
                g = 0;
                while (vif4.O_VEC_RDY !== 1'b1 && g < 100) begin tick(); g++; end
                if (g >= 100) timeouts++;
                for (int s = 0; s < stall_len; s++) begin
                    if (vif4.O_VEC_RDY !== 1'b1) rdy_drops++;
                    tick();
                end
            end
            vif4.I_VEC_VLD = 1'b1;
            g = 0;
            while (vif4.O_VEC_RDY !== 1'b1 && g < 100) begin tick(); g++; end
            if (g >= 100) timeouts++;
            tick();
        end
        vif4.I_VEC_VLD = 1'b0;
    endtask

    task automatic wait_done4(input int d0, output logic ok);
        int g = 0;
        while (n_dn4 == d0 && g < 300) begin tick(); g++; end
        ok = (n_dn4 != d0);
    endtask

    task automatic test_reset();
        n_tests++; if (shift4 !== 1'b0) begin n_fail++; $display("FAIL reset_shift: got %0d expected 0", shift4); end
        n_tests++; if (clr4 !== 1'b0) begin n_fail++; $display("FAIL reset_clr: got %0d expected 0", clr4); end
        n_tests++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0d expected 0", busy4); end
        n_tests++; if (done4 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0d expected 0", done4); end
        n_tests++; if (vif4.O_VEC_RDY !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %0d expected 0", vif4.O_VEC_RDY); end
        n_tests++; if (x4 !== 64'd0 || w4 !== 64'd0) begin n_fail++; $display("FAIL reset_skew: got %h/%h expected 0", x4, w4); end
        n_tests++; if ({shift1, clr1, busy1, done1, x1, w1} !== 36'd0) begin n_fail++; $display("FAIL reset_edge_outputs: got %h expected 0", {shift1, clr1, busy1, done1, x1, w1}); end
`ifdef SA_FEED_STALL_CNT_EN
        n_tests++; if (stall4 !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall4); end
`endif
    endtask

    task automatic test_basic();
        int b = n_sh4, c = n_clr4, d = n_dn4, to, rd;
        logic ok;
        int exp_x3 [9] = '{0, 0, 0, 3, 19, 35, 0, 0, 0};
        int exp_w3 [9] = '{0, 0, 0, 103, 119, 135, 0, 0, 0};
        int exp_x0 [9] = '{0, 16, 32, 0, 0, 0, 0, 0, 0};
        start_job4(3, 1'b0);
        feed4(3, -1, 0, to, rd);
        wait_done4(d, ok);
        tick();
        n_tests++; if (!ok || to != 0) begin n_fail++; $display("FAIL basic_timeout: got done=%0d feed_timeouts=%0d expected 1/0", ok, to); end
        n_tests++; if (n_sh4 - b != 9) begin n_fail++; $display("FAIL basic_shift_count: got %0d expected 9", n_sh4 - b); end
        n_tests++; if (n_clr4 - c != 1) begin n_fail++; $display("FAIL basic_clr_count: got %0d expected 1", n_clr4 - c); end
        n_tests++; if (n_dn4 - d != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d expected 1", n_dn4 - d); end
        for (int i = 0; i < 8; i++) begin
            n_tests++; if (sh_cyc4[b+i+1] - sh_cyc4[b+i] != 5) begin n_fail++; $display("FAIL basic_interval[%0d]: got %0d expected 5", i, sh_cyc4[b+i+1] - sh_cyc4[b+i]); end
        end
        for (int i = 0; i < 9; i++) begin
            n_tests++; if (sh_x3[b+i] !== 16'(exp_x3[i])) begin n_fail++; $display("FAIL basic_x3[%0d]: got %0d expected %0d", i+1, sh_x3[b+i], exp_x3[i]); end
            n_tests++; if (sh_w3[b+i] !== 16'(exp_w3[i])) begin n_fail++; $display("FAIL basic_w3[%0d]: got %0d expected %0d", i+1, sh_w3[b+i], exp_w3[i]); end
            n_tests++; if (sh_x0[b+i] !== 16'(exp_x0[i])) begin n_fail++; $display("FAIL basic_x0[%0d]: got %0d expected %0d", i+1, sh_x0[b+i], exp_x0[i]); end
        end
        n_tests++; if (dn_cyc4 - sh_cyc4[b+8] != LAT) begin n_fail++; $display("FAIL basic_done_latency: got %0d expected %0d", dn_cyc4 - sh_cyc4[b+8], LAT); end
        n_tests++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %0d expected 0", busy4); end
`ifdef SA_FEED_STALL_CNT_EN
        n_tests++; if (stall4 !== 16'd0) begin n_fail++; $display("FAIL basic_stall_cnt: got %0d expected 0", stall4); end
`endif
    endtask

    task automatic test_back_pressure();
        int b = n_sh4, d = n_dn4, to, rd;
        logic ok;
        int exp_x3 [9] = '{0, 0, 0, 3, 19, 35, 0, 0, 0};
        start_job4(3, 1'b0);
        feed4(3, 1, 7, to, rd);
        wait_done4(d, ok);
        tick();
        n_tests++; if (!ok || to != 0) begin n_fail++; $display("FAIL bp_timeout: got done=%0d feed_timeouts=%0d expected 1/0", ok, to); end
        n_tests++; if (rd != 0) begin n_fail++; $display("FAIL bp_rdy_held: got %0d low cycles expected 0", rd); end
        n_tests++; if (n_sh4 - b != 9) begin n_fail++; $display("FAIL bp_shift_count: got %0d expected 9", n_sh4 - b); end
        for (int i = 0; i < 8; i++) begin
            n_tests++; if (sh_cyc4[b+i+1] - sh_cyc4[b+i] != ((i == 0) ? 12 : 5)) begin n_fail++; $display("FAIL bp_interval[%0d]: got %0d expected %0d", i, sh_cyc4[b+i+1] - sh_cyc4[b+i], (i == 0) ? 12 : 5); end
        end
        for (int i = 0; i < 9; i++) begin
            n_tests++; if (sh_x3[b+i] !== 16'(exp_x3[i])) begin n_fail++; $display("FAIL bp_x3[%0d]: got %0d expected %0d", i+1, sh_x3[b+i], exp_x3[i]); end
        end
`ifdef SA_FEED_STALL_CNT_EN
        n_tests++; if (stall4 !== 16'd7) begin n_fail++; $display("FAIL bp_stall_cnt: got %0d expected 7", stall4); end
`endif
    endtask

    task automatic test_acc_mode();
        int b = n_sh4, c = n_clr4, d = n_dn4, to, rd;
        logic ok;
        start_job4(2, 1'b1);
        feed4(2, -1, 0, to, rd);
        wait_done4(d, ok);
        tick();
        n_tests++; if (!ok) begin n_fail++; $display("FAIL acc_timeout: got %0d expected 1", ok); end
        n_tests++; if (n_clr4 - c != 0) begin n_fail++; $display("FAIL acc_clr_count: got %0d expected 0", n_clr4 - c); end
        n_tests++; if (n_sh4 - b != 8) begin n_fail++; $display("FAIL acc_shift_count: got %0d expected 8", n_sh4 - b); end
        n_tests++; if (n_dn4 - d != 1) begin n_fail++; $display("FAIL acc_done_count: got %0d expected 1", n_dn4 - d); end
    endtask

    task automatic test_k_zero();
        int b = n_sh4, c = n_clr4, d = n_dn4;
        k4 = '0; acc4 = 1'b0; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        n_tests++; if (done4 !== 1'b1) begin n_fail++; $display("FAIL kzero_done: got %0d expected 1", done4); end
        n_tests++; if (busy4 !== 1'b1) begin n_fail++; $display("FAIL kzero_busy: got %0d expected 1", busy4); end
        tick();
        n_tests++; if (done4 !== 1'b0 || busy4 !== 1'b0) begin n_fail++; $display("FAIL kzero_idle: got done=%0d busy=%0d expected 0/0", done4, busy4); end
        repeat (3) tick();
        n_tests++; if (n_sh4 - b != 0 || n_clr4 - c != 0) begin n_fail++; $display("FAIL kzero_activity: got shifts=%0d clrs=%0d expected 0/0", n_sh4 - b, n_clr4 - c); end
        n_tests++; if (n_dn4 - d != 1) begin n_fail++; $display("FAIL kzero_done_count: got %0d expected 1", n_dn4 - d); end
    endtask

    task automatic test_ignored_start();
        int b = n_sh4, c = n_clr4, d = n_dn4, to, rd;
        logic ok;
        start_job4(3, 1'b0);
        fork
            feed4(3, -1, 0, to, rd);
            begin
                repeat (4) tick();
                k4 = KW'(5); acc4 = 1'b1; start4 = 1'b1;
                tick();
                start4 = 1'b0;
            end
        join
        wait_done4(d, ok);
        repeat (20) tick();
        n_tests++; if (!ok) begin n_fail++; $display("FAIL ign_timeout: got %0d expected 1", ok); end
        n_tests++; if (n_sh4 - b != 9) begin n_fail++; $display("FAIL ign_shift_count: got %0d expected 9", n_sh4 - b); end
        n_tests++; if (n_clr4 - c != 1) begin n_fail++; $display("FAIL ign_clr_count: got %0d expected 1", n_clr4 - c); end
        n_tests++; if (n_dn4 - d != 1) begin n_fail++; $display("FAIL ign_done_count: got %0d expected 1", n_dn4 - d); end
        n_tests++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL ign_busy_after: got %0d expected 0", busy4); end
    endtask

    task automatic test_reset_mid();
        int b = n_sh4, d = n_dn4, to, rd, g;
        logic ok;
        int exp_x3 [7] = '{0, 0, 0, 3, 0, 0, 0};
        start_job4(3, 1'b0);
        feed4(3, -1, 0, to, rd);
        g = 0;
        while (n_sh4 - b < 4 && g < 100) begin tick(); g++; end
        n_tests++; if (n_sh4 - b != 4) begin n_fail++; $display("FAIL rst_reach_flush: got %0d shifts expected 4", n_sh4 - b); end
        srstn4 = 1'b0;
        tick();
        n_tests++; if ({shift4, clr4, busy4, done4, vif4.O_VEC_RDY} !== 5'd0) begin n_fail++; $display("FAIL rst_ctrl_outputs: got %b expected 00000", {shift4, clr4, busy4, done4, vif4.O_VEC_RDY}); end
        n_tests++; if (x4 !== 64'd0 || w4 !== 64'd0) begin n_fail++; $display("FAIL rst_skew: got %h/%h expected 0", x4, w4); end
        srstn4 = 1'b1;
        repeat (60) tick();
        n_tests++; if (n_dn4 - d != 0) begin n_fail++; $display("FAIL rst_no_done: got %0d expected 0", n_dn4 - d); end
        n_tests++; if (n_sh4 - b != 4) begin n_fail++; $display("FAIL rst_no_more_shifts: got %0d expected 4", n_sh4 - b); end
        b = n_sh4;
        start_job4(1, 1'b0);
        feed4(1, -1, 0, to, rd);
        wait_done4(d, ok);
        tick();
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rst_fresh_timeout: got %0d expected 1", ok); end
        n_tests++; if (n_sh4 - b != 7) begin n_fail++; $display("FAIL rst_fresh_shifts: got %0d expected 7", n_sh4 - b); end
        n_tests++; if (n_dn4 - d != 1) begin n_fail++; $display("FAIL rst_fresh_done: got %0d expected 1", n_dn4 - d); end
        for (int i = 0; i < 7; i++) begin
            n_tests++; if (sh_x3[b+i] !== 16'(exp_x3[i])) begin n_fail++; $display("FAIL rst_fresh_x3[%0d]: got %0d expected %0d", i+1, sh_x3[b+i], exp_x3[i]); end
        end
    endtask

    task automatic test_edge_geometry();
        int b = n_sh1, c = n_clr1, d = n_dn1, g;
        k1 = KW'(4); acc1 = 1'b0; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vif1.I_X_VEC = 16'(16*k); vif1.I_W_VEC = 16'(100 + 16*k); vif1.I_VEC_VLD = 1'b1;
            g = 0;
            while (vif1.O_VEC_RDY !== 1'b1 && g < 20) begin tick(); g++; end
            tick();
        end
        vif1.I_VEC_VLD = 1'b0;
        g = 0;
        while (n_dn1 == d && g < 50) begin tick(); g++; end
        tick();
        n_tests++; if (n_dn1 - d != 1) begin n_fail++; $display("FAIL edge_done_count: got %0d expected 1", n_dn1 - d); end
        n_tests++; if (n_sh1 - b != 4) begin n_fail++; $display("FAIL edge_shift_count: got %0d expected 4", n_sh1 - b); end
        n_tests++; if (n_clr1 - c != 1) begin n_fail++; $display("FAIL edge_clr_count: got %0d expected 1", n_clr1 - c); end
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (sh_cyc1[b+i+1] - sh_cyc1[b+i] != 1) begin n_fail++; $display("FAIL edge_interval[%0d]: got %0d expected 1", i, sh_cyc1[b+i+1] - sh_cyc1[b+i]); end
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (sh_x1[b+i] !== 16'(16*i) || sh_w1[b+i] !== 16'(100 + 16*i)) begin n_fail++; $display("FAIL edge_skew[%0d]: got %0d/%0d expected %0d/%0d", i+1, sh_x1[b+i], sh_w1[b+i], 16*i, 100 + 16*i); end
        end
        n_tests++; if (dn_cyc1 - sh_cyc1[b+3] != LAT) begin n_fail++; $display("FAIL edge_done_latency: got %0d expected %0d", dn_cyc1 - sh_cyc1[b+3], LAT); end
`ifdef SA_FEED_STALL_CNT_EN
        n_tests++; if (stall1 !== 16'd0) begin n_fail++; $display("FAIL edge_stall_cnt: got %0d expected 0", stall1); end
`endif
    endtask

    initial begin
        arstn = 1'b0; srstn4 = 1'b1; srstn1 = 1'b1;
        start4 = 1'b0; acc4 = 1'b0; k4 = '0;
        start1 = 1'b0; acc1 = 1'b0; k1 = '0;
        vif4.I_VEC_VLD = 1'b0; vif4.I_X_VEC = '0; vif4.I_W_VEC = '0;
        vif1.I_VEC_VLD = 1'b0; vif1.I_X_VEC = '0; vif1.I_W_VEC = '0;
        repeat (3) tick();
        test_reset();
        arstn = 1'b1;
        repeat (2) tick();
        test_reset();
        test_basic();
        test_back_pressure();
        test_acc_mode();
        test_k_zero();
        test_ignored_start();
        test_reset_mid();
        test_edge_geometry();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
